// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift-add-3 iteration per clock.
// Result valid BIN_W cycles after accept; held in DONE until out_ready, no input accepted meanwhile.
module bin2bcd_seq #(
   parameter int BIN_W  = 10,
   parameter int N_DIG  = 3,
   parameter int SIGNED = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [BIN_W-1:0]           bin_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [4*N_DIG-1:0]         bcd_out,
   output logic                       neg,
   output logic                       ovf,
   output logic [$clog2(N_DIG+1)-1:0] sig_digits
);

   localparam int BCD_W = 4 * N_DIG;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int SD_W  = $clog2(N_DIG + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);
   localparam logic [BCD_W-1:0] SAT_BCD   = {N_DIG{4'h9}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [BIN_W-1:0] bin_q, bin_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_int_q, neg_int_d;
   logic             ovf_int_q, ovf_int_d;

   logic [BCD_W-1:0] bcd_out_q, bcd_out_d;
   logic             neg_out_q, neg_out_d;
   logic             ovf_out_q, ovf_out_d;
   logic [SD_W-1:0]  sig_out_q, sig_out_d;

   logic             accept;
   logic             last_iter;
   logic             in_neg;
   logic [BIN_W-1:0] mag;
   logic [BCD_W-1:0] corr;
   logic [BCD_W-1:0] bcd_shift;
   logic [BIN_W-1:0] bin_shift;
   logic             ovf_shift;
   logic [SD_W-1:0]  sig_cnt;

   assign accept    = in_valid && in_ready;
   assign last_iter = (state_q == SHIFT) && (cnt_q == LAST_ITER);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SHIFT;
         SHIFT:   if (cnt_q == LAST_ITER) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   // Negating as an unsigned BIN_W-bit value keeps -2**(BIN_W-1) representable.
   always_comb begin
      in_neg = (SIGNED != 0) && bin_in[BIN_W-1];
      mag    = in_neg ? -bin_in : bin_in;
   end

   // One double-dabble step: add-3 correction per digit, then shift {bcd,bin} left.
   always_comb begin
      corr = '0;
      for (int d = 0; d < N_DIG; d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) begin
            corr[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
         end else begin
            corr[4*d +: 4] = bcd_q[4*d +: 4];
         end
      end
      bcd_shift = {corr[BCD_W-2:0], bin_q[BIN_W-1]};
      bin_shift = {bin_q[BIN_W-2:0], 1'b0};
      ovf_shift = ovf_int_q | corr[BCD_W-1];
   end

   always_comb begin
      sig_cnt = SD_W'(1);
      for (int d = 0; d < N_DIG; d++) begin
         if (bcd_shift[4*d +: 4] != 4'd0) begin
            sig_cnt = SD_W'(d + 1);
         end
      end
   end

   // Published outputs only change on the last iteration, so they hold through IDLE.
   always_comb begin
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      neg_int_d = neg_int_q;
      ovf_int_d = ovf_int_q;
      bcd_out_d = bcd_out_q;
      neg_out_d = neg_out_q;
      ovf_out_d = ovf_out_q;
      sig_out_d = sig_out_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               bin_d     = mag;
               bcd_d     = '0;
               cnt_d     = '0;
               neg_int_d = in_neg;
               ovf_int_d = 1'b0;
            end
         end
         SHIFT: begin
            bin_d     = bin_shift;
            bcd_d     = bcd_shift;
            ovf_int_d = ovf_shift;
            cnt_d     = cnt_q + CNT_W'(1);
            if (last_iter) begin
               bcd_out_d = ovf_shift ? SAT_BCD : bcd_shift;
               neg_out_d = neg_int_q;
               ovf_out_d = ovf_shift;
               sig_out_d = ovf_shift ? SD_W'(N_DIG) : sig_cnt;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bin_q     <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         neg_int_q <= 1'b0;
         ovf_int_q <= 1'b0;
         bcd_out_q <= '0;
         neg_out_q <= 1'b0;
         ovf_out_q <= 1'b0;
         sig_out_q <= '0;
      end else begin
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
         neg_int_q <= neg_int_d;
         ovf_int_q <= ovf_int_d;
         bcd_out_q <= bcd_out_d;
         neg_out_q <= neg_out_d;
         ovf_out_q <= ovf_out_d;
         sig_out_q <= sig_out_d;
      end
   end

   assign bcd_out    = bcd_out_q;
   assign neg        = neg_out_q;
   assign ovf        = ovf_out_q;
   assign sig_digits = sig_out_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: unsigned and signed instances, vector table, corner sequences, random vs model.
module tb_bin2bcd_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       in_valid;
   logic       out_ready;
   logic       sel;
   logic [9:0] bin_in;

   logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_neg, u_ovf;
   logic [11:0] u_bcd;
   logic [1:0]  u_sd;
   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_neg, s_ovf;
   logic [11:0] s_bcd;
   logic [1:0]  s_sd;

   assign u_in_valid  = in_valid & ~sel;
   assign s_in_valid  = in_valid & sel;
   assign u_out_ready = out_ready & ~sel;
   assign s_out_ready = out_ready & sel;

   bin2bcd_seq #(.BIN_W(10), .N_DIG(3), .SIGNED(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
      .bin_in(bin_in), .out_valid(u_out_valid), .out_ready(u_out_ready),
      .bcd_out(u_bcd), .neg(u_neg), .ovf(u_ovf), .sig_digits(u_sd));

   bin2bcd_seq #(.BIN_W(10), .N_DIG(3), .SIGNED(1)) s_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .bin_in(bin_in), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .bcd_out(s_bcd), .neg(s_neg), .ovf(s_ovf), .sig_digits(s_sd));

   logic        c_in_ready, c_out_valid, c_neg, c_ovf;
   logic [11:0] c_bcd;
   logic [1:0]  c_sd;
   assign c_in_ready  = sel ? s_in_ready  : u_in_ready;
   assign c_out_valid = sel ? s_out_valid : u_out_valid;
   assign c_neg       = sel ? s_neg       : u_neg;
   assign c_ovf       = sel ? s_ovf       : u_ovf;
   assign c_bcd       = sel ? s_bcd       : u_bcd;
   assign c_sd        = sel ? s_sd        : u_sd;

   typedef struct {
      logic        sgn;
      logic [9:0]  bin;
      logic [11:0] bcd;
      logic        neg;
      logic        ovf;
      logic [1:0]  sd;
   } vec_t;

   vec_t vecs[12];

   int total = 0;
   int bad   = 0;

   logic [11:0] r_bcd;
   logic        r_neg, r_ovf;
   logic [1:0]  r_sd;
   int          r_lat;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Reference: plain decimal arithmetic on the magnitude.
   task automatic model(input logic s, input logic [9:0] v, output logic [11:0] b,
                        output logic n, output logic o, output logic [1:0] sd);
      int mag, d0, d1, d2;
      n   = s && v[9];
      mag = n ? (1024 - int'(v)) : int'(v);
      if (mag >= 1000) begin
         b  = 12'h999;
         o  = 1'b1;
         sd = 2'd3;
      end else begin
         d0 = mag % 10;
         d1 = (mag / 10) % 10;
         d2 = mag / 100;
         b  = {4'(d2), 4'(d1), 4'(d0)};
         o  = 1'b0;
         sd = (d2 != 0) ? 2'd3 : (d1 != 0) ? 2'd2 : 2'd1;
      end
   endtask

   task automatic convert(input logic [9:0] v);
      int g;
      bin_in   = v;
      in_valid = 1'b1;
      g = 0;
      while (!c_in_ready && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      if (!c_in_ready) chk("accept_timeout", 32'(c_in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      r_lat = 0;
      while (!c_out_valid && r_lat < 100) begin
         @(posedge clk); #1;
         r_lat++;
      end
      r_bcd = c_bcd;
      r_neg = c_neg;
      r_ovf = c_ovf;
      r_sd  = c_sd;
   endtask

   task automatic consume;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  32'(c_in_ready),  32'd1);
      chk({tag, "_out_valid"}, 32'(c_out_valid), 32'd0);
      chk({tag, "_bcd"},       32'(c_bcd),       32'd0);
      chk({tag, "_neg"},       32'(c_neg),       32'd0);
      chk({tag, "_ovf"},       32'(c_ovf),       32'd0);
      chk({tag, "_sd"},        32'(c_sd),        32'd0);
   endtask

   initial begin
      logic [11:0] e_bcd;
      logic        e_neg, e_ovf;
      logic [1:0]  e_sd;
      logic [9:0]  v;
      logic        seen;

      vecs[0]  = '{1'b0, 10'd0,    12'h000, 1'b0, 1'b0, 2'd1};
      vecs[1]  = '{1'b0, 10'd999,  12'h999, 1'b0, 1'b0, 2'd3};
      vecs[2]  = '{1'b0, 10'd7,    12'h007, 1'b0, 1'b0, 2'd1};
      vecs[3]  = '{1'b0, 10'd1023, 12'h999, 1'b0, 1'b1, 2'd3};
      vecs[4]  = '{1'b0, 10'd1000, 12'h999, 1'b0, 1'b1, 2'd3};
      vecs[5]  = '{1'b0, 10'd10,   12'h010, 1'b0, 1'b0, 2'd2};
      vecs[6]  = '{1'b0, 10'd100,  12'h100, 1'b0, 1'b0, 2'd3};
      vecs[7]  = '{1'b0, 10'd998,  12'h998, 1'b0, 1'b0, 2'd3};
      vecs[8]  = '{1'b1, 10'h200,  12'h512, 1'b1, 1'b0, 2'd3};
      vecs[9]  = '{1'b1, 10'h3FF,  12'h001, 1'b1, 1'b0, 2'd1};
      vecs[10] = '{1'b1, 10'd511,  12'h511, 1'b0, 1'b0, 2'd3};
      vecs[11] = '{1'b1, 10'd0,    12'h000, 1'b0, 1'b0, 2'd1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bin_in = '0; sel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("rst_u");
      sel = 1'b1;
      chk_reset_outputs("rst_s");
      sel = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         sel = vecs[i].sgn;
         convert(vecs[i].bin);
         chk($sformatf("vec%0d_lat", i), 32'(r_lat), 32'd10);
         chk($sformatf("vec%0d_bcd", i), 32'(r_bcd), 32'(vecs[i].bcd));
         chk($sformatf("vec%0d_neg", i), 32'(r_neg), 32'(vecs[i].neg));
         chk($sformatf("vec%0d_ovf", i), 32'(r_ovf), 32'(vecs[i].ovf));
         chk($sformatf("vec%0d_sd", i),  32'(r_sd),  32'(vecs[i].sd));
         consume();
         chk($sformatf("vec%0d_rdy_after", i), 32'(c_in_ready),  32'd1);
         chk($sformatf("vec%0d_vld_after", i), 32'(c_out_valid), 32'd0);
      end

      // Backpressure: result held, stray in_valid pulse ignored.
      sel = 1'b0;
      convert(10'd42);
      chk("bp_bcd0", 32'(r_bcd), 32'h042);
      for (int k = 0; k < 5; k++) begin
         in_valid = (k == 1);
         bin_in   = 10'd123;
         @(posedge clk); #1;
         chk($sformatf("bp_vld%0d", k), 32'(c_out_valid), 32'd1);
         chk($sformatf("bp_rdy%0d", k), 32'(c_in_ready),  32'd0);
         chk($sformatf("bp_bcd%0d", k), 32'(c_bcd),       32'h042);
      end
      in_valid = 1'b0;
      consume();
      chk("bp_rdy_release", 32'(c_in_ready),  32'd1);
      chk("bp_vld_release", 32'(c_out_valid), 32'd0);
      repeat (12) @(posedge clk);
      #1;
      chk("bp_no_queue_rdy", 32'(c_in_ready),  32'd1);
      chk("bp_no_queue_vld", 32'(c_out_valid), 32'd0);
      chk("bp_hold_bcd",     32'(c_bcd),       32'h042);

      // Reset during the fourth iteration aborts the conversion.
      bin_in   = 10'd512;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("abort_started", 32'(c_in_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_reset_outputs("abort");
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (c_out_valid) seen = 1'b1;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
      convert(10'd255);
      chk("post_abort_lat", 32'(r_lat), 32'd10);
      chk("post_abort_bcd", 32'(r_bcd), 32'h255);
      chk("post_abort_sd",  32'(r_sd),  32'd3);
      consume();

      // Back-to-back throughput: accept possible BIN_W+2 cycles apart.
      convert(10'd300);
      consume();
      chk("b2b_rdy", 32'(c_in_ready), 32'd1);

      for (int i = 0; i < 60; i++) begin
         sel = 1'($urandom_range(0, 1));
         v   = 10'($urandom_range(0, 1023));
         convert(v);
         model(sel, v, e_bcd, e_neg, e_ovf, e_sd);
         chk($sformatf("rnd%0d_v%0d_s%0d_bcd", i, v, sel), 32'(r_bcd), 32'(e_bcd));
         chk($sformatf("rnd%0d_v%0d_s%0d_neg", i, v, sel), 32'(r_neg), 32'(e_neg));
         chk($sformatf("rnd%0d_v%0d_s%0d_ovf", i, v, sel), 32'(r_ovf), 32'(e_ovf));
         chk($sformatf("rnd%0d_v%0d_s%0d_sd",  i, v, sel), 32'(r_sd),  32'(e_sd));
         chk($sformatf("rnd%0d_lat", i), 32'(r_lat), 32'd10);
         consume();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
